// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings and default widths.
package hazard_ctrl_pkg;

    // Default register address width of the core.
    localparam int HZ_REG_ADDR_WIDTH = 5;

    // Default width of the stall/flush performance counters.
    localparam int HZ_PERF_CNT_WIDTH = 32;

    // Controller states; encoding value 2'd3 is illegal and recovers to RUN.
    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_LOAD_STALL = 2'd1,
        HZ_MD_BUSY    = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with enable. Holds at all-ones once reached;
// clears only on the asynchronous reset.
module hazard_perf_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int WIDTH = HZ_PERF_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Increment on enable unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Resolves load-use hazards, multi-cycle mul/div occupancy of EX and
// taken-branch redirection by driving the PC / IF/ID / ID/EX enables and
// the IF/ID flush, ID/EX bubble and EX/MEM bubble controls.
// Outputs are combinational from the current state and inputs.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// stall_count / flush_count performance counters. Without it both outputs
// are tied to zero and no counter flops exist.
//
// Handshake: there is no valid/ready pair here; a stage register loads
// when its write enable is 1, and a bubble/flush replaces its contents
// with a NOP on the same edge.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = HZ_REG_ADDR_WIDTH,
    parameter int PERF_CNT_WIDTH = HZ_PERF_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ID_EX_MemRead,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic                      IF_ID_use_rs1,
    input  logic                      IF_ID_use_rs2,
    input  logic                      EX_branch_taken,
    input  logic                      EX_muldiv_start,
    input  logic                      muldiv_done,
    output logic                      PC_write,
    output logic                      IF_ID_write,
    output logic                      IF_ID_flush,
    output logic                      ID_EX_write,
    output logic                      ID_EX_bubble,
    output logic                      EX_MEM_bubble,
    output logic [PERF_CNT_WIDTH-1:0] stall_count,
    output logic [PERF_CNT_WIDTH-1:0] flush_count,
    output logic [1:0]                hz_state_o
);

    hz_state_e state_q;
    hz_state_e state_d;
    logic      lu;

    // Load in EX writes a register the ID instruction actually reads;
    // x0 never creates a dependency.
    assign lu = ID_EX_MemRead && (ID_EX_rd != '0) &&
                ((IF_ID_use_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                 (IF_ID_use_rs2 && (ID_EX_rd == IF_ID_rs2)));

    // State register; reset always returns to RUN, abandoning any stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pipeline control outputs.
    always_comb begin
        state_d       = state_q;
        PC_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_write   = 1'b1;
        ID_EX_bubble  = 1'b0;
        EX_MEM_bubble = 1'b0;
        if (rst) begin
            state_d     = HZ_RUN;
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_write = 1'b0;
        end else begin
            case (state_q)
                HZ_RUN: begin
                    if (EX_branch_taken) begin
                        // ID holds a wrong-path instruction: squash it and
                        // drop any hazard it appeared to have.
                        IF_ID_flush  = 1'b1;
                        ID_EX_bubble = 1'b1;
                    end else if (EX_muldiv_start && !muldiv_done) begin
                        PC_write      = 1'b0;
                        IF_ID_write   = 1'b0;
                        ID_EX_write   = 1'b0;
                        EX_MEM_bubble = 1'b1;
                        state_d       = HZ_MD_BUSY;
                    end else if (lu) begin
                        PC_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_bubble = 1'b1;
                        state_d      = HZ_LOAD_STALL;
                    end
                end
                HZ_LOAD_STALL: begin
                    // ID/EX now holds the bubble, so the hazard is gone.
                    state_d = HZ_RUN;
                end
                HZ_MD_BUSY: begin
                    if (!muldiv_done) begin
                        PC_write      = 1'b0;
                        IF_ID_write   = 1'b0;
                        ID_EX_write   = 1'b0;
                        EX_MEM_bubble = 1'b1;
                    end else begin
                        state_d = HZ_RUN;
                    end
                end
                default: begin
                    state_d = HZ_RUN;
                end
            endcase
        end
    end

    assign hz_state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(
        .WIDTH (PERF_CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (!PC_write),
        .count_o (stall_count)
    );

    hazard_perf_cnt #(
        .WIDTH (PERF_CNT_WIDTH)
    ) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (IF_ID_flush),
        .count_o (flush_count)
    );
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: table of vectors plus reset and saturation
// sequences. Expected outputs per cycle are packed as
// {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
//  EX_MEM_bubble, state[1:0]}.
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;

    localparam logic [7:0] E_RST = 8'b0000_0000;
    localparam logic [7:0] E_RUN = 8'b1101_0000;
    localparam logic [7:0] E_LU  = 8'b0001_1000;
    localparam logic [7:0] E_LS  = 8'b1101_0001;
    localparam logic [7:0] E_BR  = 8'b1111_1000;
    localparam logic [7:0] E_MDS = 8'b0000_0100;
    localparam logic [7:0] E_MDB = 8'b0000_0110;
    localparam logic [7:0] E_MDD = 8'b1101_0010;

    typedef struct {
        logic          mr;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic          bt;
        logic          ms;
        logic          md;
        logic [7:0]    exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ID_EX_MemRead;
    logic [AW-1:0] ID_EX_rd;
    logic [AW-1:0] IF_ID_rs1;
    logic [AW-1:0] IF_ID_rs2;
    logic          IF_ID_use_rs1;
    logic          IF_ID_use_rs2;
    logic          EX_branch_taken;
    logic          EX_muldiv_start;
    logic          muldiv_done;
    logic          PC_write;
    logic          IF_ID_write;
    logic          IF_ID_flush;
    logic          ID_EX_write;
    logic          ID_EX_bubble;
    logic          EX_MEM_bubble;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;
    logic [1:0]    hz_state_o;

    int            checks   = 0;
    int            failures = 0;
    logic [7:0]    exp_q[$];
    logic [CW-1:0] exp_stall = '0;
    logic [CW-1:0] exp_flush = '0;
    vec_t          vecs[0:20];

    hazard_ctrl #(
        .REG_ADDR_WIDTH (AW),
        .PERF_CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .ID_EX_rd        (ID_EX_rd),
        .IF_ID_rs1       (IF_ID_rs1),
        .IF_ID_rs2       (IF_ID_rs2),
        .IF_ID_use_rs1   (IF_ID_use_rs1),
        .IF_ID_use_rs2   (IF_ID_use_rs2),
        .EX_branch_taken (EX_branch_taken),
        .EX_muldiv_start (EX_muldiv_start),
        .muldiv_done     (muldiv_done),
        .PC_write        (PC_write),
        .IF_ID_write     (IF_ID_write),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_write     (ID_EX_write),
        .ID_EX_bubble    (ID_EX_bubble),
        .EX_MEM_bubble   (EX_MEM_bubble),
        .stall_count     (stall_count),
        .flush_count     (flush_count),
        .hz_state_o      (hz_state_o)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout, expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic vec_t mk(input logic mr, input logic [AW-1:0] rd,
                                input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                input logic u1, input logic u2, input logic bt,
                                input logic ms, input logic md, input logic [7:0] exp);
        vec_t v;
        v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.bt = bt; v.ms = ms; v.md = md;
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [7:0] outs_now();
        return {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write,
                ID_EX_bubble, EX_MEM_bubble, hz_state_o};
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkc(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ID_EX_MemRead   = v.mr;
        ID_EX_rd        = v.rd;
        IF_ID_rs1       = v.rs1;
        IF_ID_rs2       = v.rs2;
        IF_ID_use_rs1   = v.u1;
        IF_ID_use_rs2   = v.u2;
        EX_branch_taken = v.bt;
        EX_muldiv_start = v.ms;
        muldiv_done     = v.md;
    endtask

    // Drive one cycle, queue its expectation, compare at the falling edge.
    task automatic apply_vec(input vec_t v, input string name);
        logic [7:0] e;
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v.exp);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got empty queue, expected entry", name);
        end else begin
            e = exp_q.pop_front();
            check8(name, outs_now(), e);
            checks++;
            if (ID_EX_bubble && !ID_EX_write) begin
                failures++;
                $display("FAIL %s invariant: got bubble=1 write=0, expected not both", name);
            end
            checkc({name, " stall_count"}, stall_count, exp_stall);
            checkc({name, " flush_count"}, flush_count, exp_flush);
`ifdef HAZARD_PERF_CNT_EN
            if (!e[7] && exp_stall != {CW{1'b1}}) exp_stall = exp_stall + 1'b1;
            if (e[5] && exp_flush != {CW{1'b1}}) exp_flush = exp_flush + 1'b1;
`endif
        end
    endtask

    initial begin
        vec_t idle;
        vec_t busy;
        logic [CW-1:0] sat_exp;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        busy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_MDB);

        vecs[0]  = idle;
        vecs[1]  = mk(1, 5, 5, 0, 1, 0, 0, 0, 0, E_LU);
        vecs[2]  = mk(1, 5, 5, 0, 1, 0, 0, 0, 0, E_LS);
        vecs[3]  = idle;
        vecs[4]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, E_RUN);
        vecs[5]  = mk(1, 7, 3, 7, 1, 0, 0, 0, 0, E_RUN);
        vecs[6]  = mk(1, 9, 2, 9, 1, 1, 0, 0, 0, E_LU);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_LS);
        vecs[8]  = mk(1, 5, 5, 0, 1, 0, 1, 0, 0, E_BR);
        vecs[9]  = idle;
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_MDS);
        vecs[11] = mk(1, 5, 5, 0, 1, 0, 1, 0, 0, E_MDB);
        vecs[12] = busy;
        vecs[13] = busy;
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MDD);
        vecs[15] = idle;
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN);
        vecs[17] = mk(1, 4, 4, 0, 1, 0, 0, 1, 0, E_MDS);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MDD);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, E_BR);
        vecs[20] = idle;

        // Reset state.
        rst = 1'b1;
        drive(idle);
        #2;
        check8("reset_outs", outs_now(), E_RST);
        checkc("reset_stall_count", stall_count, '0);
        checkc("reset_flush_count", flush_count, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset while in MD_BUSY.
        apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_MDS), "md_rst_start");
        apply_vec(busy, "md_rst_busy");
        #1;
        rst = 1'b1;
        #1;
        check8("async_rst_outs", outs_now(), E_RST);
        checkc("async_rst_stall", stall_count, '0);
        checkc("async_rst_flush", flush_count, '0);
        exp_stall = '0;
        exp_flush = '0;
        @(posedge clk);
        #1;
        check8("rst_held_outs", outs_now(), E_RST);
        #2;
        rst = 1'b0;
        drive(idle);
        apply_vec(idle, "post_rst_run");

        // Long mul/div stall saturates the stall counter.
        apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_MDS), "sat_start");
        for (int i = 0; i < 20; i++) begin
            apply_vec(busy, $sformatf("sat_busy%0d", i));
        end
        apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MDD), "sat_done");
        apply_vec(idle, "sat_idle");
`ifdef HAZARD_PERF_CNT_EN
        sat_exp = {CW{1'b1}};
`else
        sat_exp = '0;
`endif
        checkc("stall_saturated", stall_count, sat_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Stall/flush controller for the 5-stage pipeline. It is the producing side of the hazard-resolution interface that the forwarding unit consumes.
- Handles load-use hazards that forwarding cannot cover.
- Handles multi-cycle mul/div occupancy of EX.
- Handles taken-branch redirection.
- Drives write-enables, bubbles and flushes for PC, IF/ID, ID/EX and EX/MEM.

Parameters:
REG_ADDR_WIDTH, 5, register address width (matches `REG_ADDR_WIDTH in const.v)
PERF_CNT_WIDTH, 32, width of stall/flush performance counters

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous, active-high reset
ID_EX_MemRead  input  1  instruction in EX is a load
ID_EX_rd  input  REG_ADDR_WIDTH  destination of instruction in EX
IF_ID_rs1  input  REG_ADDR_WIDTH  rs1 of instruction in ID
IF_ID_rs2  input  REG_ADDR_WIDTH  rs2 of instruction in ID
IF_ID_use_rs1  input  1  ID instruction reads rs1
IF_ID_use_rs2  input  1  ID instruction reads rs2
EX_branch_taken  input  1  branch/jump in EX resolved taken
EX_muldiv_start  input  1  mul/div instruction entered EX this cycle
muldiv_done  input  1  multi-cycle unit result valid this cycle
PC_write  output  1  PC register enable
IF_ID_write  output  1  IF/ID register enable
IF_ID_flush  output  1  IF/ID load NOP
ID_EX_write  output  1  ID/EX register enable
ID_EX_bubble  output  1  ID/EX load NOP (control bits zeroed)
EX_MEM_bubble  output  1  EX/MEM load NOP
stall_count  output  PERF_CNT_WIDTH  cycles with PC_write=0 (feature-gated)
flush_count  output  PERF_CNT_WIDTH  taken-branch flush events (feature-gated)

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is asynchronous, active-high.
  - While rst=1: state=RUN; counters=0; PC_write, IF_ID_write, ID_EX_write = 0; all flush/bubble outputs = 0.
  - Reset mid-stall returns to RUN immediately; no stall is resumed.
- FSM states: RUN, LOAD_STALL, MD_BUSY.
- Outputs are combinational from state and inputs (zero latency). The state register updates on posedge clk.
- Load-use detect, lu:
  - lu = ID_EX_MemRead && ID_EX_rd!=0 && ((IF_ID_use_rs1 && ID_EX_rd==IF_ID_rs1) || (IF_ID_use_rs2 && ID_EX_rd==IF_ID_rs2)).
- RUN, priority order:
  1. EX_branch_taken=1: IF_ID_flush=1, ID_EX_bubble=1, PC_write=1 (loads target). Any lu is ignored because the ID instruction is wrong-path. Next state RUN.
  2. EX_muldiv_start=1 && muldiv_done=0: PC_write=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_bubble=1. Next state MD_BUSY.
  3. lu=1: PC_write=0, IF_ID_write=0, ID_EX_bubble=1. Next state LOAD_STALL.
  4. Otherwise: all enables 1, all bubbles/flush 0.
  - EX_muldiv_start with muldiv_done in the same cycle is treated as a single-cycle op: no stall.
- LOAD_STALL:
  - Lasts exactly 1 cycle. All enables 1, bubbles 0.
  - lu is masked in this state because ID/EX holds the bubble. Branch cannot occur here.
  - Next state RUN.
- MD_BUSY:
  - While muldiv_done=0: PC_write=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_bubble=1.
  - On muldiv_done=1: all enables 1, EX_MEM_bubble=0, next state RUN.
  - EX_branch_taken and lu are ignored in this state.
- Illegal state encoding: next state RUN.
- Invariant: ID_EX_bubble and ID_EX_write=0 are never asserted together.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - stall_count increments every cycle PC_write=0 (rst low).
  - flush_count increments every cycle IF_ID_flush=1.
  - Both saturate at all-ones and clear only on rst.
- Undefined: both outputs tied to 0 and no counter flops are generated.

Decomposition:
- Shared package/const.v gets the FSM state encodings (HZ_RUN=2'd0, HZ_LOAD_STALL=2'd1, HZ_MD_BUSY=2'd2) and reuses `REG_ADDR_WIDTH / `REG_DATA_WIDTH.
- One natural sub-module: hazard_perf_cnt, a saturating counter with enable, instantiated twice under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use on rs1: ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs1=5, use_rs1=1 -> that cycle PC_write=0, IF_ID_write=0, ID_EX_bubble=1; next cycle state LOAD_STALL, all enables 1; then RUN. Repeat with rd=0 -> no stall.
- Unused operand: rd=7, IF_ID_rs2=7, use_rs2=0, rs1=3 -> no stall.
- Branch vs load-use in the same cycle: EX_branch_taken=1 with lu=1 -> IF_ID_flush=1, ID_EX_bubble=1, PC_write=1, next state RUN; flush_count +1.
- Mul/div busy for 4 cycles: EX_muldiv_start=1, muldiv_done low for 3 cycles then high -> PC_write=0 and EX_MEM_bubble=1 for 4 cycles, then enables 1 in the done cycle; stall_count=4. Start with done=1 in the same cycle -> no stall.
- Async reset mid-MD_BUSY: assert rst between clock edges -> outputs go to reset values immediately. After release, state is RUN even with muldiv_done=0, and counters are 0.
- Counter saturation (PERF_CNT_WIDTH=4, macro defined): 20 stall cycles -> stall_count=15. With the macro undefined -> stall_count=0.
